// File: rtl/nibble_packer_if.sv
// Nibble-in / word-out bus of nibble_packer. WORD_MAX exists only when
// NIBBLE_PACKER_MAX_EN is defined.
interface nibble_packer_if #(
    parameter int unsigned ADDR_W = 2
);
    logic [3:0]        NIBBLE_IN;
    logic              NIBBLE_VALID;
    logic              FLUSH;
    logic [31:0]       WORD_OUT;
    logic              WORD_VALID;
    logic              WORD_READY;
    logic              FIFO_FULL;
    logic              OVERFLOW;
    logic [ADDR_W:0]   FILL_LEVEL;
`ifdef NIBBLE_PACKER_MAX_EN
    logic [3:0]        WORD_MAX;

    modport master (
        output NIBBLE_IN, NIBBLE_VALID, FLUSH, WORD_READY,
        input  WORD_OUT, WORD_VALID, FIFO_FULL, OVERFLOW, FILL_LEVEL, WORD_MAX
    );
    modport slave (
        input  NIBBLE_IN, NIBBLE_VALID, FLUSH, WORD_READY,
        output WORD_OUT, WORD_VALID, FIFO_FULL, OVERFLOW, FILL_LEVEL, WORD_MAX
    );
`else
    modport master (
        output NIBBLE_IN, NIBBLE_VALID, FLUSH, WORD_READY,
        input  WORD_OUT, WORD_VALID, FIFO_FULL, OVERFLOW, FILL_LEVEL
    );
    modport slave (
        input  NIBBLE_IN, NIBBLE_VALID, FLUSH, WORD_READY,
        output WORD_OUT, WORD_VALID, FIFO_FULL, OVERFLOW, FILL_LEVEL
    );
`endif
endinterface

// File: rtl/nibble_packer.sv
// Packs eight nibbles LSB-first into 32-bit words and queues them in a FWFT FIFO.
// Define NIBBLE_PACKER_MAX_EN to add a per-word WORD_MAX output.
module nibble_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    nibble_packer_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e              state_q;
    logic [2:0]          cnt_q;
    logic [31:0]         pack_q;
    logic [31:0]         word_d;
    logic                push;
    logic                pop;
    logic                accept;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W:0]     fill_q;
    logic [ADDR_W:0]     fill_d;
    logic                valid_q;
    logic                full_q;
    logic                ovf_q;
    logic [31:0]         mem_q [FIFO_DEPTH];
`ifdef NIBBLE_PACKER_MAX_EN
    logic [3:0]          max_q;
    logic [3:0]          max_d;
    logic [3:0]          max_mem_q [FIFO_DEPTH];
`endif

    // The word being pushed includes a nibble arriving on the same edge; unfilled
    // slots are already zero because pack_q is cleared after every push.
    always_comb begin
        word_d = pack_q;
        if (bus.NIBBLE_VALID) begin
            word_d[{cnt_q, 2'b00} +: 4] = bus.NIBBLE_IN;
        end
        push = (bus.NIBBLE_VALID && cnt_q == 3'd7) ||
               (bus.FLUSH && (state_q == StFill || bus.NIBBLE_VALID));
`ifdef NIBBLE_PACKER_MAX_EN
        max_d = (bus.NIBBLE_VALID && bus.NIBBLE_IN > max_q) ? bus.NIBBLE_IN : max_q;
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            pack_q  <= 32'd0;
`ifdef NIBBLE_PACKER_MAX_EN
            max_q   <= 4'd0;
`endif
        end else if (push) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            pack_q  <= 32'd0;
`ifdef NIBBLE_PACKER_MAX_EN
            max_q   <= 4'd0;
`endif
        end else if (bus.NIBBLE_VALID) begin
            state_q <= StFill;
            cnt_q   <= cnt_q + 3'd1;
            pack_q  <= word_d;
`ifdef NIBBLE_PACKER_MAX_EN
            max_q   <= max_d;
`endif
        end
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO survives.
    always_comb begin
        pop    = valid_q && bus.WORD_READY;
        accept = push && (!full_q || pop);
        unique case ({accept, pop})
            2'b10:   fill_d = fill_q + (ADDR_W + 1)'(1);
            2'b01:   fill_d = fill_q - (ADDR_W + 1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            fill_q  <= fill_d;
            valid_q <= (fill_d != '0);
            full_q  <= (fill_d == (ADDR_W + 1)'(FIFO_DEPTH));
            if (push && !accept) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= word_d;
`ifdef NIBBLE_PACKER_MAX_EN
            max_mem_q[wr_ptr_q] <= max_d;
`endif
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign bus.WORD_OUT   = valid_q ? mem_q[rd_ptr_q] : 32'd0;
    assign bus.WORD_VALID = valid_q;
    assign bus.FIFO_FULL  = full_q;
    assign bus.OVERFLOW   = ovf_q;
    assign bus.FILL_LEVEL = fill_q;
`ifdef NIBBLE_PACKER_MAX_EN
    assign bus.WORD_MAX   = valid_q ? max_mem_q[rd_ptr_q] : 4'd0;
`endif
endmodule
